// File: rtl/button_pkg.sv
// Shared types and elaboration-time helpers for the push-button front end.
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_REPEATING = 2'd2
  } state_e;

  // Ceiling log2, used to size counters from parameters.
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    logic [63:0] p;
    r = 0;
    p = 64'd1;
    while (p < 64'(v)) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int unsigned max_f(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_chan.sv
// One button channel: synchroniser, debounce, and press/long/repeat FSM.
module button_chan
  import button_pkg::*;
#(
  parameter int unsigned SYNC   = 2,
  parameter int unsigned DIV    = 1500000,
  parameter int unsigned LONG   = 50000000,
  parameter int unsigned REPEAT = 10000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic button_ni,
  input  logic en_i,
  output logic hold_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int unsigned CW = clog2_f(DIV + 2);
  localparam int unsigned TW = clog2_f(max_f(max_f(LONG, REPEAT), 1) + 1);
  localparam logic [CW-1:0] CNT_DIV = CW'(DIV);
  localparam logic [CW-1:0] CNT_SAT = CW'(DIV + 1);
  localparam logic [TW-1:0] T_LONG  = TW'(LONG - 1);
  localparam logic [TW-1:0] T_REP   = TW'((REPEAT == 0) ? 0 : REPEAT - 1);

  logic [SYNC-1:0] sync_q, sync_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  state_e          state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic            hold_q, hold_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            long_q, long_d;
  logic            repeat_q, repeat_d;

  logic s_c;
  logic commit_c;
  logic press_ev_c;
  logic rel_ev_c;

  // State register for every flop in the channel.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q    <= '1;
      last_q    <= 1'b1;
      cnt_q     <= CNT_SAT;
      state_q   <= ST_IDLE;
      t_q       <= '0;
      hold_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      t_q       <= t_d;
      hold_q    <= hold_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  // Synchroniser and debounce; counter saturates at DIV+1 so a level commits once.
  always_comb begin
    sync_d   = {sync_q[SYNC-2:0], button_ni};
    s_c      = sync_q[SYNC-1];
    last_d   = s_c;
    cnt_d    = cnt_q;
    commit_c = 1'b0;
    if (s_c != last_q) begin
      cnt_d = '0;
    end else if (cnt_q < CNT_DIV) begin
      cnt_d = cnt_q + CW'(1);
    end else if (cnt_q == CNT_DIV) begin
      commit_c = 1'b1;
      cnt_d    = CNT_SAT;
    end
    press_ev_c = commit_c & ~last_q & ~hold_q;
    rel_ev_c   = commit_c & last_q & hold_q;
  end

  // Next-state: release beats any terminal count in the same cycle.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    if (!en_i || rel_ev_c) begin
      state_d = ST_IDLE;
      t_d     = '0;
    end else if (press_ev_c) begin
      state_d = ST_PRESSED;
      t_d     = '0;
    end else begin
      case (state_q)
        ST_PRESSED: begin
          if (t_q == T_LONG) begin
            state_d = ST_REPEATING;
            t_d     = '0;
          end else begin
            t_d = t_q + TW'(1);
          end
        end
        ST_REPEATING: begin
          if (REPEAT != 0) begin
            t_d = (t_q == T_REP) ? '0 : t_q + TW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          t_d     = '0;
        end
      endcase
    end
  end

  // Output decode into the registered outputs; a disabled channel is forced quiet.
  always_comb begin
    hold_d    = hold_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    if (!en_i) begin
      hold_d = 1'b0;
    end else begin
      if (press_ev_c) begin
        hold_d  = 1'b1;
        press_d = 1'b1;
      end
      if (rel_ev_c) begin
        hold_d    = 1'b0;
        release_d = 1'b1;
      end
      long_d   = ~rel_ev_c && (state_q == ST_PRESSED) && (t_q == T_LONG);
      repeat_d = ~rel_ev_c && (REPEAT != 0) && (state_q == ST_REPEATING) && (t_q == T_REP);
    end
  end

  assign hold_o    = hold_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/button_ctrl.sv
// Multi-channel push-button front end: NUM independent channels with per-channel enable.
module button_ctrl
  import button_pkg::*;
#(
  parameter int unsigned NUM    = 4,
  parameter int unsigned SYNC   = 2,
  parameter int unsigned DIV    = 1500000,
  parameter int unsigned LONG   = 50000000,
  parameter int unsigned REPEAT = 10000000
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [NUM-1:0] button_ni,
  input  logic [NUM-1:0] button_mask_i,
  output logic [NUM-1:0] button_hold_o,
  output logic [NUM-1:0] button_press_o,
  output logic [NUM-1:0] button_release_o,
  output logic [NUM-1:0] button_long_o,
  output logic [NUM-1:0] button_repeat_o
);

  // The mask gates each channel inside its output registers so gating stays registered.
  for (genvar i = 0; i < NUM; i++) begin : g_chan
    button_chan #(
      .SYNC  (SYNC),
      .DIV   (DIV),
      .LONG  (LONG),
      .REPEAT(REPEAT)
    ) u_chan (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .button_ni(button_ni[i]),
      .en_i     (button_mask_i[i]),
      .hold_o   (button_hold_o[i]),
      .press_o  (button_press_o[i]),
      .release_o(button_release_o[i]),
      .long_o   (button_long_o[i]),
      .repeat_o (button_repeat_o[i])
    );
  end

endmodule

// File: tb/tb_button_ctrl.sv
// Bench for button_ctrl: directed scenarios plus random stimulus against a
// window-and-elapsed-time reference model.
module tb_button_ctrl;

  localparam int unsigned NUM    = 2;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned DIV    = 4;
  localparam int unsigned LONG   = 20;
  localparam int unsigned REPEAT = 8;
  localparam int unsigned LAT    = SYNC + DIV + 1;
  localparam int unsigned HLEN   = SYNC + DIV + 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NUM-1:0] bn = '1;
  logic [NUM-1:0] mask = '1;
  logic [NUM-1:0] hold_o, press_o, rel_o, long_o, rep_o;

  button_ctrl #(
    .NUM(NUM), .SYNC(SYNC), .DIV(DIV), .LONG(LONG), .REPEAT(REPEAT)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .button_ni       (bn),
    .button_mask_i   (mask),
    .button_hold_o   (hold_o),
    .button_press_o  (press_o),
    .button_release_o(rel_o),
    .button_long_o   (long_o),
    .button_repeat_o (rep_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int unsigned    cyc = 0;
  logic [HLEN-1:0] hist [NUM];
  bit             m_hold [NUM];
  int unsigned    m_press_at [NUM];
  logic [NUM-1:0] e_hold = '0, e_press = '0, e_rel = '0, e_long = '0, e_rep = '0;

  // A level commits once the raw input, seen through the synchroniser delay,
  // has held for DIV+2 samples after a change; long/repeat follow from elapsed time.
  function automatic void model_step();
    logic [DIV+1:0] win;
    bit             commit;
    bit             lvl_pressed;
    int unsigned    k;
    cyc++;
    e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
    for (int ch = 0; ch < NUM; ch++) begin
      if (!rst_n) begin
        hist[ch]   = '1;
        m_hold[ch] = 1'b0;
        e_hold[ch] = 1'b0;
      end else begin
        hist[ch]    = {hist[ch][HLEN-2:0], bn[ch]};
        win         = hist[ch][SYNC+DIV+1:SYNC];
        commit      = ((win == '0) || (win == '1)) && (hist[ch][SYNC+DIV+2] != hist[ch][SYNC]);
        lvl_pressed = !hist[ch][SYNC];
        if (!mask[ch]) begin
          m_hold[ch] = 1'b0;
        end else if (commit && lvl_pressed && !m_hold[ch]) begin
          m_hold[ch]     = 1'b1;
          e_press[ch]    = 1'b1;
          m_press_at[ch] = cyc;
        end else if (commit && !lvl_pressed && m_hold[ch]) begin
          m_hold[ch] = 1'b0;
          e_rel[ch]  = 1'b1;
        end else if (m_hold[ch]) begin
          k = cyc - m_press_at[ch];
          if (k == LONG) e_long[ch] = 1'b1;
          else if (REPEAT != 0 && k > LONG && ((k - LONG) % REPEAT) == 0) e_rep[ch] = 1'b1;
        end
        e_hold[ch] = m_hold[ch];
      end
    end
  endfunction

  function automatic logic [5*NUM-1:0] obs();
    return {hold_o, press_o, rel_o, long_o, rep_o};
  endfunction

  function automatic logic [5*NUM-1:0] exp_v();
    return {e_hold, e_press, e_rel, e_long, e_rep};
  endfunction

  // Advance one clock; outputs are then examined 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    logic [5*NUM-1:0] zero;
    zero  = '0;
    rst_n = 1'b0;
    bn    = '1;
    mask  = '1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (obs() !== zero) $display("FAIL reset_held got %h exp %h", obs(), zero);
      else n_pass++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_checks++;
      if (obs() !== zero) $display("FAIL reset_quiet i=%0d got %h exp %h", i, obs(), zero);
      else n_pass++;
    end
  endtask

  task automatic test_press_long_repeat();
    int press_at, long_at, rep0, rep1;
    press_at = -1; long_at = -1; rep0 = -1; rep1 = -1;
    bn[0] = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_checks++;
      if (obs() !== exp_v()) $display("FAIL press_model i=%0d got %h exp %h", i, obs(), exp_v());
      else n_pass++;
      n_checks++;
      if ({hold_o[1], press_o[1], rel_o[1], long_o[1], rep_o[1]} !== 5'b0)
        $display("FAIL ch1_silent i=%0d got %b exp 00000", i,
                 {hold_o[1], press_o[1], rel_o[1], long_o[1], rep_o[1]});
      else n_pass++;
      if (press_o[0] && press_at < 0) press_at = i;
      if (long_o[0] && long_at < 0) long_at = i;
      if (rep_o[0]) begin
        if (rep0 < 0) rep0 = i;
        else if (rep1 < 0) rep1 = i;
      end
    end
    n_checks++;
    if (press_at != int'(LAT)) $display("FAIL press_latency got %0d exp %0d", press_at, LAT);
    else n_pass++;
    n_checks++;
    if (long_at != int'(LAT + LONG)) $display("FAIL long_time got %0d exp %0d", long_at, LAT + LONG);
    else n_pass++;
    n_checks++;
    if (rep0 != int'(LAT + LONG + REPEAT) || rep1 != int'(LAT + LONG + 2 * REPEAT))
      $display("FAIL repeat_times got %0d,%0d exp %0d,%0d", rep0, rep1,
               LAT + LONG + REPEAT, LAT + LONG + 2 * REPEAT);
    else n_pass++;
    bn[0] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_checks++;
      if (obs() !== exp_v()) $display("FAIL press_release i=%0d got %h exp %h", i, obs(), exp_v());
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    int n_press, press_at;
    n_press = 0;
    for (int i = 0; i < 45; i++) begin
      bn[0] = (i < 30 && (i % 3) == 0) ? 1'b0 : 1'b1;
      tick();
      n_checks++;
      if (obs() !== exp_v()) $display("FAIL glitch_model i=%0d got %h exp %h", i, obs(), exp_v());
      else n_pass++;
      if (press_o[0]) n_press++;
    end
    n_checks++;
    if (n_press != 0) $display("FAIL glitch_only_press got %0d exp 0", n_press);
    else n_pass++;
    n_press  = 0;
    press_at = -1;
    for (int i = 0; i < 50; i++) begin
      bn[0] = (i < 30 && (i % 3) == 0) ? 1'b1 : 1'b0;
      tick();
      n_checks++;
      if (obs() !== exp_v()) $display("FAIL bounce_model i=%0d got %h exp %h", i, obs(), exp_v());
      else n_pass++;
      if (press_o[0]) begin
        n_press++;
        press_at = i;
      end
    end
    n_checks++;
    if (n_press != 1 || press_at != 28 + int'(LAT))
      $display("FAIL bounce_press got count=%0d at=%0d exp count=1 at=%0d", n_press, press_at, 28 + LAT);
    else n_pass++;
    bn[0] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_checks++;
      if (obs() !== exp_v()) $display("FAIL bounce_release i=%0d got %h exp %h", i, obs(), exp_v());
      else n_pass++;
    end
  endtask

  task automatic test_release_on_long();
    int n_long, long_at;
    n_long = 0;
    bn[0]  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == int'(LONG)) bn[0] = 1'b1;
      tick();
      n_checks++;
      if (obs() !== exp_v()) $display("FAIL rel_long_model i=%0d got %h exp %h", i, obs(), exp_v());
      else n_pass++;
      if (long_o[0]) n_long++;
      if (i == int'(LAT + LONG)) begin
        n_checks++;
        if ({rel_o[0], long_o[0], hold_o[0]} !== 3'b100)
          $display("FAIL rel_wins got rel/long/hold=%b exp 100", {rel_o[0], long_o[0], hold_o[0]});
        else n_pass++;
      end
    end
    n_checks++;
    if (n_long != 0) $display("FAIL rel_long_count got %0d exp 0", n_long);
    else n_pass++;
    long_at = -1;
    bn[0]   = 1'b0;
    for (int i = 0; i < 35; i++) begin
      tick();
      n_checks++;
      if (obs() !== exp_v()) $display("FAIL relong_model i=%0d got %h exp %h", i, obs(), exp_v());
      else n_pass++;
      if (long_o[0] && long_at < 0) long_at = i;
    end
    n_checks++;
    if (long_at != int'(LAT + LONG)) $display("FAIL relong_time got %0d exp %0d", long_at, LAT + LONG);
    else n_pass++;
    bn[0] = 1'b1;
    for (int i = 0; i < 15; i++) tick();
  endtask

  task automatic test_mask();
    int n_press, press_at;
    bn[1] = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    n_checks++;
    if (hold_o[1] !== 1'b1) $display("FAIL mask_pre_hold got %b exp 1", hold_o[1]);
    else n_pass++;
    mask[1] = 1'b0;
    tick();
    n_checks++;
    if ({hold_o[1], press_o[1], rel_o[1], long_o[1], rep_o[1]} !== 5'b0)
      $display("FAIL mask_off got %b exp 00000", {hold_o[1], press_o[1], rel_o[1], long_o[1], rep_o[1]});
    else n_pass++;
    for (int i = 0; i < 10; i++) tick();
    mask[1] = 1'b1;
    n_press = 0;
    for (int i = 0; i < 37; i++) begin
      if (i == 25) bn[1] = 1'b1;
      tick();
      n_checks++;
      if (obs() !== exp_v()) $display("FAIL mask_model i=%0d got %h exp %h", i, obs(), exp_v());
      else n_pass++;
      if (press_o[1] || rel_o[1] || long_o[1]) n_press++;
    end
    n_checks++;
    if (n_press != 0) $display("FAIL mask_reenable_pulses got %0d exp 0", n_press);
    else n_pass++;
    press_at = -1;
    bn[1]    = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (press_o[1] && press_at < 0) press_at = i;
    end
    n_checks++;
    if (press_at != int'(LAT)) $display("FAIL mask_repress got %0d exp %0d", press_at, LAT);
    else n_pass++;
    bn[1] = 1'b1;
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_reset_mid_repeat();
    int press_at, long_at;
    logic [5*NUM-1:0] zero;
    zero  = '0;
    bn[0] = 1'b0;
    for (int i = 0; i < 45; i++) tick();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs() !== zero) $display("FAIL midrst_zero got %h exp %h", obs(), zero);
      else n_pass++;
    end
    rst_n    = 1'b1;
    press_at = -1;
    long_at  = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_checks++;
      if (obs() !== exp_v()) $display("FAIL midrst_model i=%0d got %h exp %h", i, obs(), exp_v());
      else n_pass++;
      if (press_o[0] && press_at < 0) press_at = i;
      if (long_o[0] && long_at < 0) long_at = i;
    end
    n_checks++;
    if (press_at != int'(LAT) || long_at != int'(LAT + LONG))
      $display("FAIL midrst_times got press=%0d long=%0d exp %0d/%0d", press_at, long_at, LAT, LAT + LONG);
    else n_pass++;
    bn[0] = 1'b1;
    for (int i = 0; i < 15; i++) tick();
  endtask

  task automatic test_random();
    int run [NUM];
    for (int ch = 0; ch < NUM; ch++) run[ch] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < NUM; ch++) begin
        if (run[ch] == 0) begin
          bn[ch]  = ~bn[ch];
          run[ch] = $urandom_range(1, ($urandom_range(0, 2) == 0) ? 70 : 8);
        end else begin
          run[ch]--;
        end
        if ($urandom_range(0, 249) == 0) mask[ch] = ~mask[ch];
      end
      tick();
      n_checks++;
      if (obs() !== exp_v()) $display("FAIL random_model cyc=%0d got %h exp %h", cyc, obs(), exp_v());
      else n_pass++;
    end
    mask = '1;
    bn   = '1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (obs() !== exp_v()) $display("FAIL random_drain i=%0d got %h exp %h", i, obs(), exp_v());
      else n_pass++;
    end
  endtask

  initial begin
    for (int ch = 0; ch < NUM; ch++) begin
      hist[ch]       = '1;
      m_hold[ch]     = 1'b0;
      m_press_at[ch] = 0;
    end
    test_reset();
    test_press_long_repeat();
    test_bounce();
    test_release_on_long();
    test_mask();
    test_reset_mid_repeat();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
